limbus_cpu_oci_dtrace_packer: RTL and testbench
===============================================

# limbus_cpu_oci_dtrace_packer

Producer side of the OCI data-trace capture path in the limbus CPU debug subsystem. Accepts 2-bit trace symbols from the CPU trace tap and packs them into a 30-bit `dct_buffer` with a 4-bit `dct_count`. Hands full or flushed words to the trace sink over a valid/ready handshake. Runs the end-of-test flush and reports `test_has_ended` to the simulation test bench that consumes these signals.

## Interface

Parameters:
- `SYM_W`, 2: trace symbol width.
- `NUM_SYM`, 15: symbols per word. Buffer width = `SYM_W*NUM_SYM` = 30.
- `CNT_W`, 4: count width. Must hold `NUM_SYM`.

Ports:
- `clk`, in, 1: single clock domain.
- `reset_n`, in, 1: reset is synchronous and active-low.
- `sym_valid`, in, 1: trace symbol offered.
- `sym_data`, in, 2: trace symbol.
- `sym_ready`, out, 1: symbol accepted when `sym_valid & sym_ready`.
- `test_ending`, in, 1: request to flush and terminate. Sampled every cycle.
- `dct_buffer`, out, 30: packed symbols, right-justified. Newest symbol is in bits [1:0].
- `dct_count`, out, 4: number of valid symbols in `dct_buffer`, range 0..15.
- `word_valid`, out, 1: `dct_buffer`/`dct_count` are offered to the sink.
- `word_ready`, in, 1: sink accepts when `word_valid & word_ready`.
- `test_has_ended`, out, 1: flush complete. Sticky until reset.

## Operation

- States: FILL, EMIT, DONE.
- Reset (`reset_n`=0 at a rising edge):
  - state=FILL; `dct_buffer`=0; `dct_count`=0; flush_pending=0.
  - Outputs: `word_valid`=0, `test_has_ended`=0, `sym_ready`=1.
  - Reset mid-word discards all buffered symbols.
- FILL:
  - `sym_ready`=1.
  - On accept: `dct_buffer <= {dct_buffer[27:0], sym_data}`, `dct_count++`.
  - An accept that makes `dct_count`=15 moves to EMIT.
  - `test_ending`=1 in FILL:
    - If a symbol is accepted in the same cycle, it is packed first.
    - If the resulting count is greater than 0: go to EMIT with flush_pending=1.
    - If the resulting count is 0: go directly to DONE.
- EMIT:
  - `word_valid`=1, `sym_ready`=0.
  - `dct_buffer` and `dct_count` are held stable until the handshake.
  - On `word_ready`: clear buffer and count. Go to DONE if flush_pending, else FILL.
  - `test_ending` arriving in EMIT sets flush_pending. After the handshake the state goes to DONE, with no second word, because the buffer is empty.
- DONE:
  - `test_has_ended`=1, `sym_ready`=0, `word_valid`=0.
  - Further `sym_valid` and `test_ending` are ignored until reset.
- Partial words: `dct_count` < 15. Unused upper bits of `dct_buffer` are 0.
- Count never wraps. 15 is terminal for FILL.

## Timing

- Full-word latency: `word_valid` rises the cycle after the 15th symbol is accepted.
- Minimum word period: 16 cycles (15 accepts plus 1 EMIT cycle with `word_ready`=1). `sym_ready` is low for every EMIT cycle.
- Flush latency:
  - With data buffered: `word_valid` rises 1 cycle after `test_ending` is sampled. `test_has_ended` rises 1 cycle after the handshake.
  - With an empty buffer: `test_has_ended` rises 1 cycle after `test_ending`.
- All outputs are registered, except `sym_ready`, which is a decode of the state register.
- `word_valid` never drops without a handshake except on reset.

## Structure

- Shared package `limbus_cpu_oci_pkg` holds:
  - `SYM_W`, `NUM_SYM`, `CNT_W` constants.
  - State enum `dtrace_state_t` {FILL, EMIT, DONE}.
  - Derived `DCT_BUF_W`=30.
- Single module. No sub-module: a shift register, a counter and a 3-state FSM.

## Test plan

- Reset, then 15 symbols 0,1,2,3,0,1,... with `word_ready`=1:
  - `word_valid` pulses 1 cycle after the last accept.
  - `dct_count`=15 and `dct_buffer`=30'h06C6C6C6 (oldest symbol in [29:28]).
  - Buffer and count clear afterwards.
- Full word with `word_ready` held low for 5 cycles:
  - `word_valid`, `dct_buffer` and `dct_count` stay stable.
  - `sym_ready`=0 throughout.
  - Handshake on cycle 6 returns to FILL.
- 3 symbols 3,2,1 then `test_ending`:
  - Word offered with `dct_count`=3 and `dct_buffer`=30'h39.
  - `test_has_ended`=1 one cycle after the handshake.
- `test_ending` with an empty buffer: no word emitted, and `test_has_ended`=1 one cycle later.
- Symbol 2 accepted in the same cycle as `test_ending` with 14 already buffered:
  - Single word with `dct_count`=15, then DONE.
  - Same case with 4 already buffered gives `dct_count`=5.
- `reset_n` low while in EMIT with `word_ready`=0:
  - Next cycle `word_valid`=0, `dct_count`=0, `dct_buffer`=0, state FILL.
  - `test_has_ended` also clears after reset from DONE.

Source files
------------

// File: rtl/limbus_cpu_oci_pkg.sv
// Shared constants and types for the limbus CPU OCI debug subsystem.
package limbus_cpu_oci_pkg;

  localparam int unsigned SYM_W     = 2;
  localparam int unsigned NUM_SYM   = 15;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned DCT_BUF_W = SYM_W * NUM_SYM;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } dtrace_state_t;

endpackage : limbus_cpu_oci_pkg

// File: rtl/limbus_cpu_oci_dtrace_packer.sv
// Data-trace producer: packs 2-bit trace symbols into words for the trace sink
// and runs the end-of-test flush.
module limbus_cpu_oci_dtrace_packer #(
  parameter int unsigned SYM_W   = limbus_cpu_oci_pkg::SYM_W,
  parameter int unsigned NUM_SYM = limbus_cpu_oci_pkg::NUM_SYM,
  parameter int unsigned CNT_W   = limbus_cpu_oci_pkg::CNT_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     sym_valid,
  input  logic [SYM_W-1:0]         sym_data,
  output logic                     sym_ready,
  input  logic                     test_ending,
  output logic [SYM_W*NUM_SYM-1:0] dct_buffer,
  output logic [CNT_W-1:0]         dct_count,
  output logic                     word_valid,
  input  logic                     word_ready,
  output logic                     test_has_ended
);
  import limbus_cpu_oci_pkg::*;

  localparam int unsigned BUF_W = SYM_W * NUM_SYM;

  dtrace_state_t    state;
  logic             flush_pending;
  logic             accept;
  logic [CNT_W-1:0] count_nxt;

  // Only FILL takes symbols; this is a pure decode of the state register.
  assign sym_ready = (state == FILL);
  assign accept    = sym_valid & sym_ready;
  assign count_nxt = dct_count + CNT_W'(accept);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= FILL;
      dct_buffer     <= '0;
      dct_count      <= '0;
      flush_pending  <= 1'b0;
      word_valid     <= 1'b0;
      test_has_ended <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            dct_buffer <= {dct_buffer[BUF_W-SYM_W-1:0], sym_data};
            dct_count  <= count_nxt;
          end
          // A symbol accepted alongside test_ending is packed before the flush.
          if (test_ending) begin
            if (count_nxt != '0) begin
              state         <= EMIT;
              word_valid    <= 1'b1;
              flush_pending <= 1'b1;
            end else begin
              state          <= DONE;
              test_has_ended <= 1'b1;
            end
          end else if (accept && (count_nxt == CNT_W'(NUM_SYM))) begin
            state      <= EMIT;
            word_valid <= 1'b1;
          end
        end
        EMIT: begin
          if (word_ready) begin
            dct_buffer    <= '0;
            dct_count     <= '0;
            word_valid    <= 1'b0;
            flush_pending <= 1'b0;
            if (flush_pending || test_ending) begin
              state          <= DONE;
              test_has_ended <= 1'b1;
            end else begin
              state <= FILL;
            end
          end else if (test_ending) begin
            flush_pending <= 1'b1;
          end
        end
        DONE: begin
          word_valid     <= 1'b0;
          test_has_ended <= 1'b1;
        end
        default: begin
          state      <= FILL;
          word_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule : limbus_cpu_oci_dtrace_packer

// File: tb/tb_limbus_cpu_oci_dtrace_packer.sv
// Self-checking bench for limbus_cpu_oci_dtrace_packer: directed cases plus
// randomized traffic against a queue-based reference model.
module tb_limbus_cpu_oci_dtrace_packer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sym_valid;
  logic [1:0]  sym_data;
  logic        sym_ready;
  logic        test_ending;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        word_valid;
  logic        word_ready;
  logic        test_has_ended;

  int checks = 0;
  int errors = 0;

  // Reference model: symbols held, word offered, flush requested, test ended.
  int q[$];
  bit m_offer;
  bit m_flush;
  bit m_ended;

  always #5 clk = ~clk;

  limbus_cpu_oci_dtrace_packer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .sym_valid      (sym_valid),
    .sym_data       (sym_data),
    .sym_ready      (sym_ready),
    .test_ending    (test_ending),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .word_valid     (word_valid),
    .word_ready     (word_ready),
    .test_has_ended (test_has_ended)
  );

  // Packed value of the held symbols: oldest most significant, base-4 digits.
  function automatic logic [31:0] model_buf();
    longint v = 0;
    foreach (q[i]) v = v * 4 + longint'(q[i]);
    return 32'(v);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    if (!reset_n) begin
      q.delete();
      m_offer = 1'b0;
      m_flush = 1'b0;
      m_ended = 1'b0;
    end else if (m_ended) begin
      // terminal until reset
    end else if (m_offer) begin
      if (test_ending) m_flush = 1'b1;
      if (word_ready) begin
        q.delete();
        m_offer = 1'b0;
        if (m_flush) m_ended = 1'b1;
        m_flush = 1'b0;
      end
    end else begin
      if (sym_valid) q.push_back(int'(sym_data));
      if (test_ending) begin
        if (q.size() > 0) begin
          m_offer = 1'b1;
          m_flush = 1'b1;
        end else begin
          m_ended = 1'b1;
        end
      end else if (q.size() == 15) begin
        m_offer = 1'b1;
      end
    end
  endtask

  // Drive one cycle of inputs, clock it, then compare every output to the model.
  task automatic cyc(input logic rn, input logic sv, input logic [1:0] sd,
                     input logic te, input logic wr, input string tag);
    reset_n     = rn;
    sym_valid   = sv;
    sym_data    = sd;
    test_ending = te;
    word_ready  = wr;
    model_edge();
    @(posedge clk);
    #1;
    chk({tag, ".word_valid"}, 32'(word_valid), 32'(m_offer));
    chk({tag, ".ended"}, 32'(test_has_ended), 32'(m_ended));
    chk({tag, ".sym_ready"}, 32'(sym_ready), 32'(!m_offer && !m_ended));
    chk({tag, ".count"}, 32'(dct_count), 32'(q.size()));
    chk({tag, ".buffer"}, 32'(dct_buffer), model_buf());
  endtask

  task automatic fill(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 2'($urandom), 1'b0, 1'b0, tag);
  endtask

  initial begin
    reset_n     = 1'b0;
    sym_valid   = 1'b0;
    sym_data    = 2'd0;
    test_ending = 1'b0;
    word_ready  = 1'b0;

    cyc(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, "reset");
    cyc(1'b0, 1'b1, 2'd3, 1'b1, 1'b1, "reset_busy_inputs");
    chk("reset_sym_ready", 32'(sym_ready), 32'd1);
    chk("reset_count", 32'(dct_count), 32'd0);

    // Full word 0,1,2,3,... with the sink always ready.
    for (int i = 0; i < 15; i++) cyc(1'b1, 1'b1, 2'(i % 4), 1'b0, 1'b1, "full_fill");
    chk("full_wv", 32'(word_valid), 32'd1);
    chk("full_count", 32'(dct_count), 32'd15);
    chk("full_buf", 32'(dct_buffer), 32'h06C6_C6C6);
    cyc(1'b1, 1'b1, 2'd1, 1'b0, 1'b1, "full_hs");
    chk("full_cleared", 32'(dct_count), 32'd0);

    // Sink stalls for 5 cycles; word must hold, handshake on the 6th.
    fill(15, "stall_fill");
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b1, 2'($urandom), 1'b0, 1'b0, "stall_hold");
      chk("stall_sym_ready", 32'(sym_ready), 32'd0);
    end
    cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, "stall_hs");
    chk("stall_back_to_fill", 32'(sym_ready), 32'd1);

    // Partial flush of 3,2,1.
    cyc(1'b1, 1'b1, 2'd3, 1'b0, 1'b0, "part_s0");
    cyc(1'b1, 1'b1, 2'd2, 1'b0, 1'b0, "part_s1");
    cyc(1'b1, 1'b1, 2'd1, 1'b0, 1'b0, "part_s2");
    cyc(1'b1, 1'b0, 2'd0, 1'b1, 1'b0, "part_end");
    chk("part_wv", 32'(word_valid), 32'd1);
    chk("part_count", 32'(dct_count), 32'd3);
    chk("part_buf", 32'(dct_buffer), 32'h39);
    cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, "part_hs");
    chk("part_ended", 32'(test_has_ended), 32'd1);
    cyc(1'b1, 1'b1, 2'd2, 1'b1, 1'b1, "part_done_ignores");
    cyc(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, "part_reset");
    chk("reset_clears_ended", 32'(test_has_ended), 32'd0);

    // Flush with nothing buffered.
    cyc(1'b1, 1'b0, 2'd0, 1'b1, 1'b1, "empty_end");
    chk("empty_ended", 32'(test_has_ended), 32'd1);
    chk("empty_no_word", 32'(word_valid), 32'd0);
    cyc(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, "empty_reset");

    // Symbol accepted together with test_ending, 14 and 4 already buffered.
    fill(14, "edge14_fill");
    cyc(1'b1, 1'b1, 2'd2, 1'b1, 1'b0, "edge14_end");
    chk("edge14_count", 32'(dct_count), 32'd15);
    cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, "edge14_hs");
    chk("edge14_ended", 32'(test_has_ended), 32'd1);
    cyc(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, "edge14_reset");
    fill(4, "edge4_fill");
    cyc(1'b1, 1'b1, 2'd2, 1'b1, 1'b0, "edge4_end");
    chk("edge4_count", 32'(dct_count), 32'd5);
    cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, "edge4_hs");
    cyc(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, "edge4_reset");

    // test_ending during a stalled EMIT: one word only, then done.
    fill(15, "late_fill");
    cyc(1'b1, 1'b0, 2'd0, 1'b1, 1'b0, "late_end");
    cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, "late_hs");
    chk("late_ended", 32'(test_has_ended), 32'd1);
    cyc(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, "late_reset");

    // Reset while a word is stalled in EMIT.
    fill(15, "rst_emit_fill");
    cyc(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, "rst_emit");
    chk("rst_emit_wv", 32'(word_valid), 32'd0);
    chk("rst_emit_buf", 32'(dct_buffer), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic rn;
      rn = !(m_ended && ($urandom_range(0, 3) == 0)) && ($urandom_range(0, 499) != 0);
      cyc(rn, ($urandom_range(0, 3) != 0), 2'($urandom), ($urandom_range(0, 149) == 0),
          ($urandom_range(0, 2) != 0), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_limbus_cpu_oci_dtrace_packer
